// File: rtl/tohost_pkg.sv
// tohost_pkg: shared state encoding and default addresses for the tohost monitor.
package tohost_pkg;
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;
  localparam logic [31:0] DEF_TOHOST_ADDR  = 32'h0000_1000;
  localparam logic [31:0] DEF_PUTCHAR_ADDR = 32'h0000_1004;
  localparam logic [31:0] PASS_VALUE       = 32'd1;
endpackage

// File: rtl/console_fifo.sv
// console_fifo: byte-wide synchronous FIFO with extra-bit pointers for full detection.
module console_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout = mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = do_push ? wr_q + ONE : wr_q;
    rd_d = do_pop ? rd_q + ONE : rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/tohost_monitor.sv
// tohost_monitor: snoops data-memory writes for the tohost verdict, console bytes and a watchdog.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
  parameter logic [31:0] PUTCHAR_ADDR   = DEF_PUTCHAR_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 6000,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_code,
  output logic [31:0] cycle_count,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        con_overflow
);
  localparam bit WD_EN = TIMEOUT_CYCLES != 0;
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] ONE32 = 32'd1;
  state_e state_q, state_d;
  logic [30:0] fail_q, fail_d;
  logic [31:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic tohost_hit, putchar_hit, con_push, con_pop, con_full, con_empty;
  logic unused_addr;
  assign unused_addr = ^mem_addr[1:0];
  assign tohost_hit = mem_we && (mem_addr[31:2] == TOHOST_ADDR[31:2]);
  assign putchar_hit = mem_we && (mem_addr[31:2] == PUTCHAR_ADDR[31:2]);
  assign con_push = putchar_hit;
  assign con_valid = !con_empty;
  assign con_pop = con_valid && con_ready;
  always_comb begin
    state_d = state_q;
    fail_d = fail_q;
    cnt_d = cnt_q;
    if (state_q == ST_RUN) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + ONE32;
      // Only odd tohost values carry a verdict; even ones are syscalls and ignored.
      if (tohost_hit && mem_wdata[0]) begin
        state_d = (mem_wdata == PASS_VALUE) ? ST_PASS : ST_FAIL;
        fail_d = (mem_wdata == PASS_VALUE) ? '0 : mem_wdata[31:1];
      end else if (WD_EN && cnt_q == WD_LAST) begin
        state_d = ST_TIMEOUT;
      end
    end
    ovf_d = ovf_q | (con_push && con_full && !con_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      fail_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q <= fail_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign done = state_q != ST_RUN;
  assign pass = state_q == ST_PASS;
  assign timeout = state_q == ST_TIMEOUT;
  assign fail_code = fail_q;
  assign cycle_count = cnt_q;
  assign con_overflow = ovf_q;
  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (con_push),
    .din  (mem_wdata[7:0]),
    .pop  (con_pop),
    .dout (con_data),
    .empty(con_empty),
    .full (con_full)
  );
endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: directed stimulus with queued expectations checked by a negedge monitor.
module tb_tohost_monitor;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;
  localparam logic [31:0] PUTCHAR = 32'h0000_1004;
  typedef struct {
    logic        pass;
    logic        tmo;
    logic [30:0] code;
    logic [31:0] cnt;
  } verdict_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic con_ready = 1'b0;
  logic done, pass, timeout, con_valid, con_overflow;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;
  logic [7:0] con_data;
  int nvec = 0;
  int nfail = 0;
  logic [7:0] exp_bytes[$];
  verdict_t exp_v[$];
  logic prev_done = 1'b0;
  always #5 clk = ~clk;
  tohost_monitor #(
    .TOHOST_ADDR(TOHOST), .PUTCHAR_ADDR(PUTCHAR), .TIMEOUT_CYCLES(50), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .pass(pass), .timeout(timeout), .fail_code(fail_code),
    .cycle_count(cycle_count), .con_valid(con_valid), .con_data(con_data),
    .con_ready(con_ready), .con_overflow(con_overflow)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    tick();
    mem_we = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_bytes.delete();
    exp_v.delete();
  endtask
  task automatic expect_v(input logic p, input logic t, input logic [30:0] c, input logic [31:0] n);
    verdict_t v;
    v.pass = p;
    v.tmo = t;
    v.code = c;
    v.cnt = n;
    exp_v.push_back(v);
  endtask
  always @(negedge clk) begin
    if (con_valid && con_ready) begin
      if (exp_bytes.size() == 0) chk("con_unexpected", {24'd0, con_data}, 32'hFFFF_FFFF);
      else chk("con_byte", {24'd0, con_data}, {24'd0, exp_bytes.pop_front()});
    end
    if (done && !prev_done) begin
      if (exp_v.size() == 0) chk("verdict_unexpected", 32'd1, 32'd0);
      else begin
        verdict_t v;
        v = exp_v.pop_front();
        chk("v_pass", {31'd0, pass}, {31'd0, v.pass});
        chk("v_timeout", {31'd0, timeout}, {31'd0, v.tmo});
        chk("v_fail_code", {1'b0, fail_code}, {1'b0, v.code});
        chk("v_cycle_count", cycle_count, v.cnt);
      end
    end
    prev_done = done;
  end
  initial begin
    idle(2);
    rst = 1'b0;
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pass", {31'd0, pass}, 0);
    chk("rst_timeout", {31'd0, timeout}, 0);
    chk("rst_fail_code", {1'b0, fail_code}, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_con_valid", {31'd0, con_valid}, 0);
    chk("rst_con_overflow", {31'd0, con_overflow}, 0);
    // pass at cycle 20
    idle(20);
    expect_v(1, 0, 0, 21);
    wr(TOHOST, 1);
    idle(3);
    chk("pass_frozen_cnt", cycle_count, 21);
    // fail code, then absorbing
    do_reset();
    idle(3);
    expect_v(0, 0, 31'd3, 4);
    wr(TOHOST, 7);
    wr(TOHOST, 1);
    idle(2);
    chk("fail_absorb_pass", {31'd0, pass}, 0);
    chk("fail_absorb_code", {1'b0, fail_code}, 3);
    chk("fail_absorb_cnt", cycle_count, 4);
    chk("fail_absorb_done", {31'd0, done}, 1);
    // watchdog
    do_reset();
    idle(49);
    chk("wd_not_yet", {31'd0, done}, 0);
    chk("wd_cnt49", cycle_count, 49);
    expect_v(0, 1, 0, 50);
    idle(3);
    chk("wd_timeout_held", {31'd0, timeout}, 1);
    chk("wd_cnt_frozen", cycle_count, 50);
    // tohost wins over simultaneous expiry
    do_reset();
    idle(49);
    expect_v(1, 0, 0, 50);
    wr(TOHOST, 1);
    idle(1);
    // ignored writes: syscall values and foreign addresses
    do_reset();
    wr(TOHOST, 0);
    wr(TOHOST, 4);
    wr(32'h0000_2000, 1);
    wr(32'h0000_1008, 1);
    chk("ignored_done", {31'd0, done}, 0);
    expect_v(1, 0, 0, 5);
    wr(TOHOST, 1);
    idle(1);
    // console "OK\n" with back-pressure
    do_reset();
    con_ready = 1'b0;
    exp_bytes.push_back(8'h4F);
    exp_bytes.push_back(8'h4B);
    exp_bytes.push_back(8'h0A);
    wr(PUTCHAR, 32'hABCD_004F);
    wr(PUTCHAR, 32'h0000_004B);
    wr(PUTCHAR, 32'h1234_560A);
    idle(2);
    chk("con_hold_valid", {31'd0, con_valid}, 1);
    chk("con_hold_data", {24'd0, con_data}, 32'h4F);
    con_ready = 1'b1;
    for (int i = 0; i < 10 && con_valid; i++) tick();
    chk("con_drained", {31'd0, con_valid}, 0);
    chk("con_no_ovf", {31'd0, con_overflow}, 0);
    // overflow, full push+pop, reset mid-drain
    do_reset();
    con_ready = 1'b0;
    expect_v(1, 0, 0, 1);
    wr(TOHOST, 1);
    for (int i = 0; i < 16; i++) begin
      exp_bytes.push_back(8'(i));
      wr(PUTCHAR, 32'(i));
    end
    chk("ovf_before", {31'd0, con_overflow}, 0);
    wr(PUTCHAR, 32'h10);
    chk("ovf_set", {31'd0, con_overflow}, 1);
    con_ready = 1'b1;
    exp_bytes.push_back(8'h80);
    wr(PUTCHAR, 32'h80);
    idle(8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_bytes.delete();
    exp_v.delete();
    chk("rst_mid_valid", {31'd0, con_valid}, 0);
    chk("rst_mid_ovf", {31'd0, con_overflow}, 0);
    chk("rst_mid_done", {31'd0, done}, 0);
    idle(3);
    chk("rst_mid_still_empty", {31'd0, con_valid}, 0);
    con_ready = 1'b0;
    // full push+pop kept 0x80 and nothing was lost before reset
    do_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_bytes.push_back(8'(8'h20 + i));
      wr(PUTCHAR, 32'(8'h20 + i));
    end
    con_ready = 1'b1;
    exp_bytes.push_back(8'hC3);
    wr(PUTCHAR, 32'hC3);
    chk("full_pushpop_no_ovf", {31'd0, con_overflow}, 0);
    for (int i = 0; i < 24 && con_valid; i++) tick();
    chk("full_pushpop_drained", {31'd0, con_valid}, 0);
    idle(2);
    chk("pending_bytes", exp_bytes.size(), 0);
    chk("pending_verdicts", exp_v.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/tohost_monitor.md
Name: tohost_monitor

Overview:
Hardware end of the riscv-tests "tohost" completion protocol. It snoops the core's data-memory write port, decodes writes to the TOHOST word into a sticky pass/fail/timeout verdict, buffers console bytes written to a PUTCHAR address, and enforces a cycle watchdog. It sits beside the core's data memory in simulation and FPGA builds. It replaces PC/register peeking in benches with a single status interface.

Parameters:
TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word; word-aligned match on addr[31:2]
PUTCHAR_ADDR, 32'h0000_1004, byte address of the console byte sink; word-aligned match on addr[31:2]
TIMEOUT_CYCLES, 6000, run cycles before the TIMEOUT verdict; 0 disables the watchdog
FIFO_DEPTH, 16, console FIFO entries; must be a power of 2 and at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
mem_we  in  1  data-memory write enable; one write per cycle
mem_addr  in  32  data-memory write byte address
mem_wdata  in  32  data-memory write data
done  out  1  verdict reached; sticky
pass  out  1  tohost==1 received; valid when done
timeout  out  1  watchdog expired; valid when done
fail_code  out  31  tohost>>1 on failure; 0 otherwise
cycle_count  out  32  cycles since reset; frozen at done
con_valid  out  1  console byte available
con_data  out  8  console byte (FIFO head)
con_ready  in  1  consumer accepts byte when con_valid&&con_ready
con_overflow  out  1  sticky; a console byte was dropped because the FIFO was full

Behaviour:
- Reset (rst high at a clk edge): state RUN. done, pass and timeout are 0. fail_code, cycle_count, con_valid and con_overflow are 0. FIFO is emptied.
- States:
  - RUN -> PASS on a tohost write with wdata==1.
  - RUN -> FAIL on a tohost write with wdata odd and not 1; fail_code <= wdata[31:1].
  - RUN -> TIMEOUT when cycle_count==TIMEOUT_CYCLES-1 and no qualifying tohost write occurs that cycle.
  - PASS, FAIL and TIMEOUT are absorbing until rst.
- Tohost wdata==0 or even nonzero (syscall encoding, unsupported): ignored, state stays RUN.
- Latency: a write sampled at edge N makes done and its verdict outputs visible after edge N; all outputs are registered.
- Simultaneous tohost write and watchdog expiry in the same cycle: the tohost verdict wins.
- cycle_count increments by 1 every cycle in RUN. It holds its value once any verdict state is entered. It saturates at 32'hFFFF_FFFF and does not wrap.
- Writes to TOHOST_ADDR once done is high are ignored; verdict outputs never change after done.
- PUTCHAR write: push wdata[7:0] into the FIFO. This is accepted in any state, so trailing prints after the verdict are kept.
- FIFO full and a push arrives with no pop that cycle: the byte is dropped and con_overflow is set.
- FIFO full with a push and a pop in the same cycle: both succeed; count is unchanged.
- FIFO empty: con_valid=0. A push lands and con_valid goes high the next cycle; first-word-fall-through is not required.
- con_data is stable while con_valid&&!con_ready.
- Addresses other than TOHOST and PUTCHAR are ignored entirely. The monitor never stalls or back-pressures the core.
- rst asserted mid-run or after done: all state returns to reset values on that edge, and any queued console bytes are discarded.

Decomposition:
- Shared package tohost_pkg:
  - state encoding (RUN, PASS, FAIL, TIMEOUT; 2 bits)
  - default TOHOST/PUTCHAR address constants
  - the PASS_VALUE=1 constant
- Sub-module console_fifo: synchronous FIFO with push/pop, full/empty, parameterised depth and width 8, using pointer-plus-extra-bit full detection.
- Verdict FSM and watchdog are in the top module.

Test Plan:
- Reset, then tohost write 0x1 at cycle 20 -> done=1, pass=1, fail_code=0 one edge later; cycle_count frozen at 21.
- Tohost write 0x7 -> done=1, pass=0, timeout=0, fail_code=3. A later write of 0x1 leaves all outputs unchanged.
- No tohost write, TIMEOUT_CYCLES=50 -> done=1, timeout=1 after exactly 50 run cycles. Rerun with tohost 0x1 on cycle 49: pass=1, timeout=0 (tohost wins).
- Tohost writes 0x0 and 0x4, then 0x1 -> the first two are ignored (done stays 0); pass=1 after the third.
- Write "OK\n" to PUTCHAR with con_ready=0, then raise con_ready -> bytes 0x4F, 0x4B, 0x0A delivered in order, then con_valid=0.
- FIFO_DEPTH=16: 17 PUTCHAR writes with con_ready=0 -> con_overflow=1; 16 bytes drained. Assert rst mid-drain -> con_valid=0, con_overflow=0, done=0 on the next cycle.
